// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed RV32I loads/stores into one or two
// word accesses with byte enables, shifted write data and extended load data.
module lsu_align #(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [31:0]       o_rsp_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_next;
  logic        we_reg, err_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg, wdata_reg, rd0_reg, rd1_reg;

  logic [1:0]  off;
  logic [7:0]  base_mask, m8;
  logic [63:0] wd64;
  logic [31:0] ld;
  logic        req_legal, ready_int;
  logic        unused_addr;

  function automatic logic legal_f3(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  assign req_legal   = legal_f3(i_req_we, i_req_funct3);
  assign unused_addr = ^addr_reg[31:ADDR_W+2];

  // Byte lanes of the access across a two-word window; the upper nibble marks the second word.
  assign off = addr_reg[1:0];
  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
  end
  assign m8   = base_mask << off;
  assign wd64 = {32'b0, wdata_reg} << {off, 3'b000};
  assign ld   = 32'({rd1_reg, rd0_reg} >> {off, 3'b000});

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= 32'b0;
      wdata_reg  <= 32'b0;
      rd0_reg    <= 32'b0;
      rd1_reg    <= 32'b0;
    end else begin
      if (state == IDLE && i_req_valid) begin
        we_reg     <= i_req_we;
        err_reg    <= ~req_legal;
        funct3_reg <= i_req_funct3;
        addr_reg   <= i_req_addr;
        wdata_reg  <= i_req_wdata;
        rd1_reg    <= 32'b0;
      end
      if (state == ACC0) rd0_reg <= i_mem_rdata;
      if (state == ACC1) rd1_reg <= i_mem_rdata;
    end
  end

  always_comb begin
    state_next  = state;
    ready_int   = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = 32'b0;
    o_mem_addr  = '0;
    o_mem_wdata = 32'b0;
    o_mem_bmask = 4'b0;
    o_mem_wren  = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        if (i_req_valid) state_next = req_legal ? ACC0 : RESP;
      end
      ACC0: begin
        o_mem_addr  = addr_reg[ADDR_W+1:2];
        o_mem_bmask = m8[3:0];
        o_mem_wdata = wd64[31:0];
        o_mem_wren  = we_reg;
        state_next  = (m8[7:4] != 4'b0) ? ACC1 : RESP;
      end
      ACC1: begin
        o_mem_addr  = addr_reg[ADDR_W+1:2] + ADDR_W'(1);
        o_mem_bmask = m8[7:4];
        o_mem_wdata = wd64[63:32];
        o_mem_wren  = we_reg;
        state_next  = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_reg;
        if (!we_reg && !err_reg) begin
          case (funct3_reg)
            3'b000:  o_rsp_rdata = {{24{ld[7]}}, ld[7:0]};
            3'b001:  o_rsp_rdata = {{16{ld[15]}}, ld[15:0]};
            3'b100:  o_rsp_rdata = {24'b0, ld[7:0]};
            3'b101:  o_rsp_rdata = {16'b0, ld[15:0]};
            default: o_rsp_rdata = ld;
          endcase
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready stays low while reset is held even though the state already reads IDLE.
  assign o_req_ready = ready_int & ~i_reset;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-masked word memory model.
module tb_lsu_align;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = 32'b0;
  logic [31:0]       req_wdata = 32'b0;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_bmask;
  logic              mem_wren;

  logic [31:0] mem [0:65535];
  int tests = 0;
  int fails = 0;
  int lat;

  lsu_align #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_bmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle, then scrambles the request inputs.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b011; req_addr = ~addr; req_wdata = ~wd;
  endtask

  task automatic wait_rsp(output int l);
    l = 1;
    while (rsp_valid !== 1'b1 && l < 8) begin
      cyc();
      l++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 32'b0;
    cyc();
    cyc();
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_mem_outputs", {mem_wdata[15:0], mem_addr[11:0], mem_bmask}, 32'd0);
    chk("reset_wren", 32'(mem_wren), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    cyc();

    // Aligned word store
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("sw_addr", 32'(mem_addr), 32'h40);
    chk("sw_bmask", 32'(mem_bmask), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_wren", 32'(mem_wren), 32'd1);
    chk("sw_ready_busy", 32'(req_ready), 32'd0);
    cyc();
    chk("sw_rsp_lat2", 32'(rsp_valid), 32'd1);
    chk("sw_rsp_rdata", rsp_rdata, 32'd0);
    chk("sw_rsp_err", 32'(rsp_err), 32'd0);
    chk("sw_mem", mem[16'h40], 32'hDEAD_BEEF);
    $display("[TB] SW  0x100 data=deadbeef rsp_valid=%0d", rsp_valid);
    cyc();
    chk("sw_rsp_pulse", 32'(rsp_valid), 32'd0);

    // Byte loads, signed and unsigned
    mem[16'h40] <= 32'h8011_2233;
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_bmask", 32'(mem_bmask), 32'h8);
    chk("lb_wren", 32'(mem_wren), 32'd0);
    wait_rsp(lat);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    $display("[TB] LB  0x103 rdata=%08h lat=%0d", rsp_rdata, lat);
    cyc();
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    wait_rsp(lat);
    chk("lbu_rdata", rsp_rdata, 32'h0000_0080);
    $display("[TB] LBU 0x103 rdata=%08h lat=%0d", rsp_rdata, lat);
    cyc();

    // Word-crossing halfword store
    issue(1'b1, 3'b001, 32'h0000_0107, 32'h0000_A1B2);
    chk("sh_acc0", {mem_wdata[31:24], 8'h0, mem_addr[7:0], 4'h0, mem_bmask},
        {8'hB2, 8'h0, 8'h41, 4'h0, 4'h8});
    chk("sh_acc0_wdata", mem_wdata, 32'hB200_0000);
    cyc();
    chk("sh_acc1_addr", 32'(mem_addr), 32'h42);
    chk("sh_acc1_bmask", 32'(mem_bmask), 32'h1);
    chk("sh_acc1_wdata", mem_wdata, 32'h0000_00A1);
    chk("sh_acc1_wren", 32'(mem_wren), 32'd1);
    cyc();
    chk("sh_rsp_lat3", 32'(rsp_valid), 32'd1);
    chk("sh_mem41", mem[16'h41], 32'hB200_0000);
    chk("sh_mem42", mem[16'h42], 32'h0000_00A1);
    $display("[TB] SH  0x107 data=a1b2 rsp_valid=%0d", rsp_valid);
    cyc();

    // Word-crossing word load
    mem[16'h40] <= 32'h3322_1100;
    mem[16'h41] <= 32'h7766_5544;
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    wait_rsp(lat);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rsp_rdata, 32'h5544_3322);
    $display("[TB] LW  0x102 rdata=%08h lat=%0d", rsp_rdata, lat);
    cyc();

    // Halfword load crossing the top of the word space
    mem[16'hFFFF] <= 32'hAABB_CCDD;
    mem[16'h0000] <= 32'h1122_33C4;
    issue(1'b0, 3'b001, 32'h0003_FFFF, 32'h0);
    chk("wrap_acc0_addr", 32'(mem_addr), 32'hFFFF);
    chk("wrap_acc0_bmask", 32'(mem_bmask), 32'h8);
    cyc();
    chk("wrap_acc1_addr", 32'(mem_addr), 32'h0000);
    chk("wrap_acc1_bmask", 32'(mem_bmask), 32'h1);
    wait_rsp(lat);
    chk("wrap_rdata", rsp_rdata, 32'hFFFF_C4AA);
    $display("[TB] LH  0x3ffff rdata=%08h lat=%0d", rsp_rdata, lat);
    cyc();

    // Illegal funct3 for a store and for a load
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678);
    chk("err_st_valid", 32'(rsp_valid), 32'd1);
    chk("err_st_err", 32'(rsp_err), 32'd1);
    chk("err_st_wren", 32'(mem_wren), 32'd0);
    chk("err_st_rdata", rsp_rdata, 32'd0);
    $display("[TB] ST f3=100 err=%0d", rsp_err);
    cyc();
    chk("err_st_idle", 32'(req_ready), 32'd1);
    chk("err_st_mem", mem[16'h40], 32'h3322_1100);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    chk("err_ld_err", 32'(rsp_err), 32'd1);
    $display("[TB] LD f3=011 err=%0d", rsp_err);
    cyc();

    // Reset while the second half of a crossing store is on the bus
    mem[16'h41] <= 32'hFFFF_FFFF;
    mem[16'h42] <= 32'h1234_5678;
    issue(1'b1, 3'b010, 32'h0000_0106, 32'hCAFE_F00D);
    chk("rst_acc0_bmask", 32'(mem_bmask), 32'hC);
    chk("rst_acc0_wdata", mem_wdata, 32'hF00D_0000);
    cyc();
    chk("rst_acc1_wdata", mem_wdata, 32'h0000_CAFE);
    chk("rst_acc1_wren", 32'(mem_wren), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_abort_wren", 32'(mem_wren), 32'd0);
    chk("rst_abort_bmask", 32'(mem_bmask), 32'd0);
    chk("rst_abort_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_abort_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("rst_mem41_partial", mem[16'h41], 32'hF00D_FFFF);
    chk("rst_mem42_untouched", mem[16'h42], 32'h1234_5678);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    $display("[TB] SW 0x106 aborted by reset mem41=%08h mem42=%08h", mem[16'h41], mem[16'h42]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
